// File: rtl/parity_pkg.sv
// Shared parity definitions for the parity encoder/decoder pair.
//   - parity sense constants (even/odd)
//   - parity bit position constants (LSB/MSB)
//   - calc_parity(): reduction XOR over a zero-extended word
//   - occ_e: occupancy state of the decoder's two-entry skid buffer
package parity_pkg;

  localparam int unsigned ParityEven = 0;
  localparam int unsigned ParityOdd  = 1;

  localparam int unsigned PosLsb = 0;
  localparam int unsigned PosMsb = 1;

  // Widest encoded word the helper accepts; callers zero-extend into it.
  localparam int unsigned ParityMaxW = 64;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } occ_e;

  // XOR of all bits. Zero padding does not change the result.
  function automatic logic calc_parity(input logic [ParityMaxW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/decoder_skid.sv
// Two-entry skid buffer between the parity checker and the consumer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_data_i      word to store (payload and error flag packed)
//   in_push_i      store in_data_i this cycle (caller qualifies with in_ready_o)
//   in_ready_o     registered "buffer not full"
//   out_data_o     head entry, held stable while not accepted
//   out_valid_o    head entry is valid
//   out_ready_i    consumer accepts the head entry
module decoder_skid
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_push_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             ready_q, ready_d;
  logic             pop;

  assign pop = (state_q != StEmpty) && out_ready_i;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      StEmpty: begin
        if (in_push_i) begin
          slot0_d = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_push_i && pop) begin
          slot0_d = in_data_i;
        end else if (in_push_i) begin
          slot1_d = in_data_i;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // No push is possible here: in_ready_o is low while full.
        if (pop) begin
          slot0_d = slot1_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Ready is registered from the next occupancy so it never depends
    // combinationally on out_ready_i.
    ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      slot0_q <= '0;
      slot1_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = slot0_q;
  assign out_valid_o = (state_q != StEmpty);

endmodule

// File: rtl/parity_decoder.sv
// Parity decoder: checks parity of words popped from a FIFO, strips the
// parity bit and forwards {payload, err} through a two-entry skid buffer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pop_data_i     encoded word (DATA_WIDTH+1 bits)
//   pop_valid_i    pop_data_i valid
//   pop_grant_o    decoder accepts a word this cycle (registered)
//   out_data_o     decoded payload
//   out_valid_o    out_data_o / out_err_o valid
//   out_grant_i    consumer accepts the output word
//   out_err_o      parity error flag of the output word
//   err_sticky_o   any error seen since last clear
//   err_count_o    saturating error count
//   err_clr_i      synchronous clear of sticky flag and counter
module parity_decoder
  import parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EVEN_ODD   = 0,
  parameter int unsigned PARITY_BIT = 0,
  parameter int unsigned DROP_ERR   = 0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   pop_data_i,
  input  logic                  pop_valid_i,
  output logic                  pop_grant_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_grant_i,
  output logic                  out_err_o,
  output logic                  err_sticky_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  input  logic                  err_clr_i
);

  logic                  in_xfer;
  logic                  word_err;
  logic                  err_xfer;
  logic                  push;
  logic [DATA_WIDTH-1:0] payload;
  logic [DATA_WIDTH:0]   skid_out;

  logic                  sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0]  count_q, count_d;

  assign in_xfer  = pop_valid_i && pop_grant_o;
  assign word_err = calc_parity(ParityMaxW'(pop_data_i)) != (EVEN_ODD == ParityOdd);
  assign err_xfer = in_xfer && word_err;
  // Errored words are still accepted and counted; with DROP_ERR they never
  // enter the buffer.
  assign push     = in_xfer && !((DROP_ERR != 0) && word_err);

  always_comb begin
    payload = '0;
    if (PARITY_BIT == PosMsb) begin
      payload = pop_data_i[DATA_WIDTH-1:0];
    end else begin
      payload = pop_data_i[DATA_WIDTH:1];
    end
  end

  decoder_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({payload, word_err}),
    .in_push_i   (push),
    .in_ready_o  (pop_grant_o),
    .out_data_o  (skid_out),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_grant_i)
  );

  assign out_data_o = skid_out[DATA_WIDTH:1];
  assign out_err_o  = skid_out[0];

  // Clear is applied before the increment so a same-cycle error survives.
  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    if (err_clr_i) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end
    if (err_xfer) begin
      sticky_d = 1'b1;
      if (count_d != {ERR_CNT_W{1'b1}}) begin
        count_d = count_d + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign err_count_o  = count_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_parity_decoder.sv
// Directed bench for parity_decoder. Three instances share clock, reset,
// valid and grant: dut_a default, dut_b DROP_ERR=1, dut_c odd/MSB parity.
module tb_parity_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] pop_data;
  logic [8:0] c_data;
  logic       pop_valid;
  logic       out_grant;
  logic       err_clr;

  logic       a_grant, a_valid, a_err, a_sticky;
  logic [7:0] a_data, a_count;
  logic       b_grant, b_valid, b_err, b_sticky;
  logic [7:0] b_data, b_count;
  logic       c_grant, c_valid, c_err, c_sticky;
  logic [7:0] c_out, c_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  parity_decoder dut_a (
    .clk(clk), .rst_n(rst_n), .pop_data_i(pop_data), .pop_valid_i(pop_valid),
    .pop_grant_o(a_grant), .out_data_o(a_data), .out_valid_o(a_valid),
    .out_grant_i(out_grant), .out_err_o(a_err), .err_sticky_o(a_sticky),
    .err_count_o(a_count), .err_clr_i(err_clr)
  );

  parity_decoder #(.DROP_ERR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pop_data_i(pop_data), .pop_valid_i(pop_valid),
    .pop_grant_o(b_grant), .out_data_o(b_data), .out_valid_o(b_valid),
    .out_grant_i(out_grant), .out_err_o(b_err), .err_sticky_o(b_sticky),
    .err_count_o(b_count), .err_clr_i(err_clr)
  );

  parity_decoder #(.EVEN_ODD(1), .PARITY_BIT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .pop_data_i(c_data), .pop_valid_i(pop_valid),
    .pop_grant_o(c_grant), .out_data_o(c_out), .out_valid_o(c_valid),
    .out_grant_i(out_grant), .out_err_o(c_err), .err_sticky_o(c_sticky),
    .err_count_o(c_count), .err_clr_i(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    pop_data  = '0;
    c_data    = 9'h155;
    pop_valid = 1'b0;
    out_grant = 1'b0;
    err_clr   = 1'b0;

    // Reset state
    #12;
    check("rst_valid", a_valid, 0);
    check("rst_grant", a_grant, 0);
    check("rst_data", a_data, 0);
    check("rst_err", a_err, 0);
    check("rst_count", a_count, 0);
    check("rst_sticky", a_sticky, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("grant_after_rst", a_grant, 1);

    // Single good word
    @(negedge clk);
    pop_data = 9'h0AA; pop_valid = 1'b1; out_grant = 1'b1;
    @(posedge clk) #1;
    check("single_valid", a_valid, 1);
    check("single_data", a_data, 8'h55);
    check("single_err", a_err, 0);
    check("odd_msb_valid", c_valid, 1);
    check("odd_msb_data", c_out, 8'h55);
    check("odd_msb_err", c_err, 0);
    @(negedge clk) pop_valid = 1'b0;
    @(posedge clk) #1;
    check("single_drained", a_valid, 0);

    // Bad parity
    @(negedge clk);
    pop_data = 9'h0AB; pop_valid = 1'b1;
    @(posedge clk) #1;
    check("bad_valid", a_valid, 1);
    check("bad_data", a_data, 8'h55);
    check("bad_err", a_err, 1);
    check("bad_count", a_count, 1);
    check("bad_sticky", a_sticky, 1);
    check("drop_valid", b_valid, 0);
    check("drop_count", b_count, 1);
    @(negedge clk) pop_valid = 1'b0;
    @(posedge clk) #1;
    check("bad_drained", a_valid, 0);

    // Backpressure: 002/004 carry bad even parity, 006 is good
    @(negedge clk);
    out_grant = 1'b0; pop_valid = 1'b1; pop_data = 9'h002;
    @(posedge clk) #1;
    check("bp_grant_one", a_grant, 1);
    @(negedge clk) pop_data = 9'h004;
    @(posedge clk) #1;
    check("bp_grant_full", a_grant, 0);
    @(negedge clk) pop_data = 9'h006;
    @(posedge clk) #1;
    check("bp_grant_held", a_grant, 0);
    check("bp_stable_data", a_data, 8'h01);
    check("bp_stable_err", a_err, 1);
    @(negedge clk) out_grant = 1'b1;
    @(posedge clk) #1;
    check("bp_second", a_data, 8'h02);
    check("bp_second_err", a_err, 1);
    check("bp_grant_back", a_grant, 1);
    @(posedge clk) #1;
    check("bp_third", a_data, 8'h03);
    check("bp_third_err", a_err, 0);
    @(negedge clk) pop_valid = 1'b0;
    @(posedge clk) #1;
    check("bp_empty", a_valid, 0);
    check("bp_count", a_count, 3);

    // Saturation with 260 errored words
    @(negedge clk);
    pop_data = 9'h0AB; pop_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    check("sat_count", a_count, 255);
    check("sat_drop_count", b_count, 255);
    check("sat_drop_valid", b_valid, 0);
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk) #1;
    check("clr_err_count", a_count, 1);
    check("clr_err_sticky", a_sticky, 1);
    @(negedge clk) pop_valid = 1'b0;
    @(posedge clk) #1;
    check("clr_only_count", a_count, 0);
    check("clr_only_sticky", a_sticky, 0);
    @(negedge clk) err_clr = 1'b0;

    // Reset while full
    @(negedge clk);
    out_grant = 1'b0; pop_valid = 1'b1; pop_data = 9'h003;
    @(posedge clk);
    @(posedge clk) #1;
    check("pre_rst_full", a_grant, 0);
    check("pre_rst_valid", a_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_grant", a_grant, 0);
    check("mid_rst_data", a_data, 0);
    @(negedge clk);
    rst_n = 1'b1; pop_data = 9'h00A;
    @(posedge clk) #1;
    check("post_rst_grant", a_grant, 1);
    check("post_rst_no_out", a_valid, 0);
    @(posedge clk) #1;
    check("post_rst_valid", a_valid, 1);
    check("post_rst_data", a_data, 8'h05);
    check("post_rst_err", a_err, 0);
    @(negedge clk);
    pop_valid = 1'b0; out_grant = 1'b1;
    @(posedge clk) #1;
    check("post_rst_drained", a_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
